// File: rtl/farm_sensor_conditioner_pkg.sv
// Shared lamp codes, debounce state encoding and a lamp decode helper for the
// farm-road sensor conditioner.
package traffic_pkg;

    localparam logic [1:0] SIG_GREEN  = 2'b01;
    localparam logic [1:0] SIG_YELLOW = 2'b10;
    localparam logic [1:0] SIG_RED    = 2'b11;

    typedef enum logic [1:0] {
        DB_LOW,
        DB_RISE,
        DB_HIGH,
        DB_FALL
    } db_state_e;

    // 00 is an undefined lamp code and is deliberately treated as not-green.
    function automatic logic is_green(input logic [1:0] code);
        return code == SIG_GREEN;
    endfunction

endpackage

// File: rtl/farm_sensor_conditioner_if.sv
// Loop/lamp inputs and demand/count outputs of the farm sensor conditioner.
// master = side driving the loop and lamp feedback, slave = the conditioner.
interface farm_sensor_conditioner_if #(
    parameter int CNT_W = 8
);
    logic             raw_loop;
    logic [1:0]       farm_signal;
    logic             sensor;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] vehicle_total;
    logic             stuck_fault;

    modport master (
        output raw_loop, farm_signal,
        input  sensor, pending, vehicle_total, stuck_fault
    );

    modport slave (
        input  raw_loop, farm_signal,
        output sensor, pending, vehicle_total, stuck_fault
    );
endinterface

// File: rtl/farm_sensor_conditioner_loop_debounce.sv
// Two-flop synchronizer plus LOW/RISE/HIGH/FALL debounce of the inductive loop.
// Filtered level and the one-cycle arrival pulse are both registered; no backpressure.
module loop_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic arrival_o
);

    localparam int            CW     = 8;
    localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_CYCLES);

    logic          meta_q;
    logic          sync_q;
    db_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          arrival_q;

    // cnt_q counts stable samples of the opposite level seen so far; it is 0
    // in LOW/HIGH, which lets the settled and transient states share one branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q    <= 1'b0;
            sync_q    <= 1'b0;
            state_q   <= DB_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            arrival_q <= 1'b0;
        end else begin
            meta_q    <= raw_i;
            sync_q    <= meta_q;
            arrival_q <= 1'b0;
            case (state_q)
                DB_LOW, DB_RISE: begin
                    if (!sync_q) begin
                        state_q <= DB_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q + 1'b1 == TARGET) begin
                        state_q   <= DB_HIGH;
                        cnt_q     <= '0;
                        level_q   <= 1'b1;
                        arrival_q <= 1'b1;
                    end else begin
                        state_q <= DB_RISE;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                DB_HIGH, DB_FALL: begin
                    if (sync_q) begin
                        state_q <= DB_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q + 1'b1 == TARGET) begin
                        state_q <= DB_LOW;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        state_q <= DB_FALL;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= DB_LOW;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign arrival_o = arrival_q;

endmodule

// File: rtl/farm_sensor_conditioner.sv
// Farm-road loop conditioner: debounced arrivals, pending/total counts, registered demand.
// Arrival reaches sensor 2+DEBOUNCE_CYCLES edges after raw rise; no backpressure.
// Optional stuck-loop fail-safe enabled by defining SENSOR_STUCK_DETECT_EN.
module farm_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 64,
    parameter int CNT_W           = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    farm_sensor_conditioner_if.slave   bus
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 1..255");
    end
    if (STUCK_CYCLES < 2 || STUCK_CYCLES > 65535) begin : g_bad_stuck
        $error("STUCK_CYCLES out of range 2..65535");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             level;
    logic             arrival;
    logic             service;
    logic             prev_green_q;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             sensor_q, sensor_d;
    logic             stuck_q, stuck_d;

    loop_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .raw_i     (bus.raw_loop),
        .level_o   (level),
        .arrival_o (arrival)
    );

    assign service = is_green(bus.farm_signal) && !prev_green_q;

    always_comb begin
        pending_d = pending_q;
        if (service) begin
            pending_d = arrival ? CNT_W'(1) : '0;
        end else if (arrival && pending_q != CNT_MAX) begin
            pending_d = pending_q + 1'b1;
        end
        total_d  = total_q + CNT_W'(arrival);
        sensor_d = (pending_d != '0) || stuck_d;
    end

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int            SW           = 16;
    localparam logic [SW-1:0] STUCK_TARGET = SW'(STUCK_CYCLES);

    logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;

    // Count saturates at the target so a loop held for hours cannot wrap
    // and drop the fault while still occupied.
    always_comb begin
        stuck_cnt_d = '0;
        stuck_d     = 1'b0;
        if (level) begin
            stuck_cnt_d = (stuck_cnt_q == STUCK_TARGET) ? stuck_cnt_q : stuck_cnt_q + 1'b1;
            stuck_d     = stuck_q || (stuck_cnt_d == STUCK_TARGET);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stuck_cnt_q <= '0;
        end else begin
            stuck_cnt_q <= stuck_cnt_d;
        end
    end
`else
    // The filtered level only feeds the stuck detector.
    logic unused_level;
    assign unused_level = level;
    assign stuck_d      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_green_q <= 1'b1;
            pending_q    <= '0;
            total_q      <= '0;
            sensor_q     <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            prev_green_q <= is_green(bus.farm_signal);
            pending_q    <= pending_d;
            total_q      <= total_d;
            sensor_q     <= sensor_d;
            stuck_q      <= stuck_d;
        end
    end

    assign bus.sensor        = sensor_q;
    assign bus.pending       = pending_q;
    assign bus.vehicle_total = total_q;
    assign bus.stuck_fault   = stuck_q;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Bench for farm_sensor_conditioner: vector table, directed corner sequences and
// a randomized run against a run-length reference model.
module tb_farm_sensor_conditioner;
    import traffic_pkg::*;

    localparam int D = 4;
    localparam int S = 64;
    localparam int W = 8;
    localparam int MAXC = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    farm_sensor_conditioner_if #(.CNT_W(W)) bus ();

    farm_sensor_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .STUCK_CYCLES    (S),
        .CNT_W           (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total_n = 0;
    int bad_n   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_n++;
        if (act != exp) begin
            bad_n++;
            if (bad_n <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bus.raw_loop    = 1'b0;
        bus.farm_signal = SIG_RED;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Reference model: synchronizer delay line, then a run-length counter of
    // samples disagreeing with the filtered level.
    int m_s1, m_s2, m_level, m_run, m_arr, m_pending, m_total, m_prev_green;
    int m_scnt, m_fault, m_sensor;

    task automatic model_step(input int r, input logic [1:0] s, input int rs);
        int arr;
        int service;
        if (rs != 0) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_arr = 0;
            m_pending = 0; m_total = 0; m_prev_green = 1;
            m_scnt = 0; m_fault = 0; m_sensor = 0;
            return;
        end
        arr     = m_arr;
        service = (s == SIG_GREEN && m_prev_green == 0) ? 1 : 0;
        if (service != 0)  m_pending = arr;
        else if (arr != 0) m_pending = (m_pending == MAXC) ? MAXC : m_pending + 1;
        m_total      = (m_total + arr) % (MAXC + 1);
        m_prev_green = (s == SIG_GREEN) ? 1 : 0;
`ifdef SENSOR_STUCK_DETECT_EN
        if (m_level != 0) begin
            if (m_scnt < S) m_scnt++;
            if (m_scnt == S) m_fault = 1;
        end else begin
            m_scnt  = 0;
            m_fault = 0;
        end
`endif
        m_arr = 0;
        if (m_s2 != m_level) begin
            m_run++;
            if (m_run == D) begin
                m_level = m_s2;
                m_run   = 0;
                m_arr   = m_s2;
            end
        end else begin
            m_run = 0;
        end
        m_s2     = m_s1;
        m_s1     = r;
        m_sensor = (m_pending != 0 || m_fault != 0) ? 1 : 0;
    endtask

    typedef struct {
        int   high_len;
        int   exp_total;
        int   exp_pending;
        logic exp_sensor;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int raw_left, sig_left, r;
        logic [1:0] sg;

        vecs[0] = '{1,  0, 0, 1'b0};
        vecs[1] = '{3,  0, 0, 1'b0};
        vecs[2] = '{4,  1, 1, 1'b1};
        vecs[3] = '{10, 2, 2, 1'b1};
        vecs[4] = '{2,  2, 2, 1'b1};
        vecs[5] = '{5,  3, 3, 1'b1};

        // Reset state while rst is held.
        rst = 1'b1; bus.raw_loop = 1'b1; bus.farm_signal = SIG_GREEN;
        repeat (3) tick();
        chk("rst_sensor",  bus.sensor, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_total",   bus.vehicle_total, 0);
        chk("rst_stuck",   bus.stuck_fault, 0);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.raw_loop = 1'b1;
            repeat (vecs[i].high_len) tick();
            bus.raw_loop = 1'b0;
            repeat (12) tick();
            chk($sformatf("vec%0d_total", i),   bus.vehicle_total, vecs[i].exp_total);
            chk($sformatf("vec%0d_pending", i), bus.pending,       vecs[i].exp_pending);
            chk($sformatf("vec%0d_sensor", i),  bus.sensor,        vecs[i].exp_sensor);
        end

        // Service after three queued vehicles.
        repeat (3) tick();
        chk("svc_pre_pending", bus.pending, 3);
        bus.farm_signal = SIG_GREEN;
        tick();
        chk("svc_pending", bus.pending, 0);
        chk("svc_sensor",  bus.sensor, 0);
        tick();
        chk("svc_sensor_next", bus.sensor, 0);

        // Arrival latency: sensor rises 6 edges after the raw rise edge.
        do_reset();
        bus.raw_loop = 1'b1;
        repeat (6) tick();
        chk("lat_sensor_early", bus.sensor, 0);
        tick();
        chk("lat_sensor",  bus.sensor, 1);
        chk("lat_pending", bus.pending, 1);
        chk("lat_total",   bus.vehicle_total, 1);
        repeat (3) tick();
        bus.raw_loop = 1'b0;
        repeat (12) tick();
        chk("lat_one_arrival", bus.vehicle_total, 1);

        // Arrival on the same edge as the service event.
        bus.raw_loop = 1'b1;
        repeat (6) tick();
        bus.farm_signal = SIG_GREEN;
        tick();
        chk("coinc_pending", bus.pending, 1);
        chk("coinc_sensor",  bus.sensor, 1);
        bus.raw_loop = 1'b0;
        repeat (20) tick();
        chk("green_hold_sensor", bus.sensor, 1);
        bus.farm_signal = SIG_YELLOW;
        repeat (3) tick();
        chk("yellow_hold_sensor", bus.sensor, 1);
        bus.farm_signal = 2'b00;
        tick();
        bus.farm_signal = SIG_GREEN;
        tick();
        chk("svc_after_00", bus.pending, 0);

        // Reset mid-debounce discards the partial count.
        bus.farm_signal = SIG_RED;
        bus.raw_loop = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("rstmid_sensor_early", bus.sensor, 0);
        tick();
        chk("rstmid_sensor", bus.sensor, 1);
        bus.raw_loop = 1'b0;
        repeat (12) tick();

        // 256 arrivals without green: pending saturates, total wraps.
        do_reset();
        repeat (256) begin
            bus.raw_loop = 1'b1;
            repeat (5) tick();
            bus.raw_loop = 1'b0;
            repeat (8) tick();
        end
        chk("ovf_pending", bus.pending, MAXC);
        chk("ovf_total",   bus.vehicle_total, 0);
        chk("ovf_sensor",  bus.sensor, 1);

        // Loop held high.
        do_reset();
        bus.raw_loop = 1'b1;
        repeat (69) tick();
`ifdef SENSOR_STUCK_DETECT_EN
        chk("stuck_early", bus.stuck_fault, 0);
        tick();
        chk("stuck_set", bus.stuck_fault, 1);
        bus.farm_signal = SIG_GREEN;
        tick();
        chk("stuck_green_pending", bus.pending, 0);
        chk("stuck_green_sensor",  bus.sensor, 1);
        repeat (5) tick();
        chk("stuck_green_hold", bus.sensor, 1);
        bus.raw_loop = 1'b0;
        repeat (6) tick();
        chk("stuck_hold_db", bus.stuck_fault, 1);
        tick();
        chk("stuck_clear",        bus.stuck_fault, 0);
        chk("stuck_clear_sensor", bus.sensor, 0);
        bus.raw_loop = 1'b1;
        repeat (40) tick();
        rst = 1'b1;
        tick();
        chk("stuck_rst_fault",   bus.stuck_fault, 0);
        chk("stuck_rst_sensor",  bus.sensor, 0);
        chk("stuck_rst_pending", bus.pending, 0);
        chk("stuck_rst_total",   bus.vehicle_total, 0);
        rst = 1'b0;
        bus.raw_loop = 1'b0;
        repeat (12) tick();
`else
        tick();
        chk("nostuck_fault",  bus.stuck_fault, 0);
        chk("nostuck_sensor", bus.sensor, 1);
        bus.farm_signal = SIG_GREEN;
        tick();
        chk("nostuck_green_sensor", bus.sensor, 0);
        bus.raw_loop = 1'b0;
        repeat (12) tick();
`endif

        // Randomized run against the reference model.
        do_reset();
        model_step(0, SIG_RED, 1);
        raw_left = 0;
        sig_left = 0;
        r  = 0;
        sg = SIG_RED;
        for (int c = 0; c < 3000; c++) begin
            if (raw_left == 0) begin
                r = (r == 0) ? 1 : 0;
                raw_left = (c % 700 < 100) ? $urandom_range(70, 90) : $urandom_range(1, 8);
            end
            if (sig_left == 0) begin
                sg = 2'($urandom_range(0, 3));
                sig_left = $urandom_range(1, 20);
            end
            raw_left--;
            sig_left--;
            bus.raw_loop    = r[0];
            bus.farm_signal = sg;
            rst = ($urandom_range(0, 299) == 0);
            tick();
            model_step(r, sg, rst ? 1 : 0);
            chk("rnd_sensor",  bus.sensor, m_sensor);
            chk("rnd_pending", bus.pending, m_pending);
            chk("rnd_total",   bus.vehicle_total, m_total);
            chk("rnd_stuck",   bus.stuck_fault, m_fault);
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule

// File: doc/farm_sensor_conditioner.md
FARM_SENSOR_CONDITIONER -- requirements
Module: farm_sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to change the filtered loop level; legal range 1..255.
REQ-002 Parameter STUCK_CYCLES, default 64: consecutive filtered-high cycles that declare a stuck loop; legal range 2..65535.
REQ-003 Parameter CNT_W, default 8: width of the pending and total vehicle counters.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 raw_loop  input  1  asynchronous farm-road inductive loop contact; 1 = metal present.
REQ-007 farm_signal  input  2  farm lamp code fed back from the signal controller: 01 green, 10 yellow, 11 red.
REQ-008 sensor  output  1  registered vehicle-demand request to the signal controller.
REQ-009 pending  output  CNT_W  vehicles queued since last farm green; saturating.
REQ-010 vehicle_total  output  CNT_W  total arrivals since reset; wraps modulo 2^CNT_W.
REQ-011 stuck_fault  output  1  loop held occupied for too long.

Function
REQ-012 raw_loop shall pass through a two-flop synchronizer; sync_q is the second flop.
REQ-013 Debounce FSM states: LOW, RISE, HIGH, FALL.
  - LOW -> RISE when sync_q = 1.
  - RISE -> HIGH when sync_q has been 1 for DEBOUNCE_CYCLES consecutive cycles.
  - RISE -> LOW when sync_q = 0; the counter clears.
  - HIGH/FALL are symmetric on sync_q = 0.
REQ-014 The filtered level shall be 1 in HIGH and FALL, and 0 in LOW and RISE.
REQ-015 An arrival shall be the single cycle on which the FSM enters HIGH.
REQ-016 A raw rise sampled at edge k, held stable, shall produce an arrival at edge k+1+DEBOUNCE_CYCLES and sensor = 1 one edge later.
REQ-017 Each arrival shall increment vehicle_total, wrapping from all-ones to 0.
REQ-018 Each arrival shall increment pending, saturating at 2^CNT_W-1.
REQ-019 Service event: the first cycle farm_signal = 01 after a cycle with farm_signal != 01.
  - On a service event, pending shall clear to 0.
REQ-020 Arrival and service event on the same cycle: pending shall become 1.
REQ-021 sensor shall be registered and equal to (pending != 0) OR stuck_fault, from the updated values.
REQ-022 sensor shall stay asserted through farm green and yellow if new arrivals occur after the service event.
REQ-023 A farm_signal value of 00 shall be treated as not-green; it never causes a service event.

Reset
REQ-024 While rst = 1, the following shall be 0: synchronizer flops, debounce counter, pending, vehicle_total, stuck counter, stuck_fault, sensor.
  - The FSM shall be in LOW.
  - The previous-green flag shall be set to 1, so that green present at release is not a service event.
REQ-025 rst asserted mid-debounce or mid-stuck-count shall discard partial counts; rst has priority over all other events.

Configuration
REQ-026 Macro SENSOR_STUCK_DETECT_EN, when defined:
  - A stuck counter shall count cycles with filtered level 1, clearing when the level is 0.
  - stuck_fault shall set on the cycle the count reaches STUCK_CYCLES and clear on the first cycle the filtered level is 0.
  - While stuck_fault = 1, sensor shall be forced to 1, so the fail-safe keeps the farm road served.
REQ-027 When SENSOR_STUCK_DETECT_EN is undefined:
  - The stuck counter shall be absent.
  - stuck_fault shall be tied to 0.
  - sensor = (pending != 0).

Structure
REQ-028 Package traffic_pkg shall hold:
  - lamp code constants SIG_GREEN = 01, SIG_YELLOW = 10, SIG_RED = 11;
  - the debounce state enum.
REQ-029 Sub-module loop_debounce shall contain the synchronizer and debounce FSM.
  - It is parameterized by DEBOUNCE_CYCLES.
  - It outputs the filtered level and a one-cycle arrival pulse.

Verification
REQ-030 raw_loop high for 10 cycles with DEBOUNCE_CYCLES = 4 -> exactly one arrival; pending = 1, vehicle_total = 1, sensor = 1 six edges after the raw rise.
REQ-031 Glitch: raw_loop high for 3 cycles, then low -> no arrival; pending = 0, sensor = 0.
REQ-032 Three clean vehicles, then farm_signal 11 -> 01 -> pending goes 3 -> 0 on the green edge, and sensor = 0 the following edge.
REQ-033 Arrival coincident with the service edge -> pending = 1, sensor remains 1.
REQ-034 Pending overflow with CNT_W = 8: 256 arrivals, no green -> pending = 255 (saturated), vehicle_total = 0 (wrapped).
REQ-035 With SENSOR_STUCK_DETECT_EN and STUCK_CYCLES = 64: raw_loop held high -> stuck_fault = 1 after 64 filtered-high cycles, and sensor = 1 across a farm green; release raw_loop -> stuck_fault clears after debounce; rst pulsed mid-count -> all outputs 0.
